// File: rtl/addr_4_if.sv
// rtl/addr_4_if.sv - operand/result bundle for addr_4; ovf/zero exist only with ADDR_4_FLAGS_EN
interface addr_4_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             out_valid;
`ifdef ADDR_4_FLAGS_EN
    logic             ovf;
    logic             zero;

    modport master (output a, b, cin, in_valid, input s, cout, out_valid, ovf, zero);
    modport slave  (input a, b, cin, in_valid, output s, cout, out_valid, ovf, zero);
`else
    modport master (output a, b, cin, in_valid, input s, cout, out_valid);
    modport slave  (input a, b, cin, in_valid, output s, cout, out_valid);
`endif
endinterface

// File: rtl/addr_4.sv
// rtl/addr_4.sv - registered carry-lookahead adder, 1-cycle latency; ADDR_4_FLAGS_EN adds ovf/zero flags
module addr_4 #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    addr_4_if.slave    bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             term;
    logic             c_acc;

    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    // Each carry is the flattened lookahead sum-of-products, not a ripple chain.
    always_comb begin
        g     = bus.a & bus.b;
        p     = bus.a ^ bus.b;
        carry = '0;
        term  = 1'b0;
        c_acc = 1'b0;
        carry[0] = bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            term = bus.cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c_acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c_acc = c_acc | term;
            end
            carry[i+1] = c_acc;
        end
        sum = p ^ carry[WIDTH-1:0];
    end

    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            s_d    = sum;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = out_valid_q;

`ifdef ADDR_4_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (bus.in_valid) begin
            ovf_d  = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            zero_d = (sum == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_addr_4.sv
// tb/tb_addr_4.sv - directed and exhaustive self-checking bench for addr_4 (ADDR_4_FLAGS_EN optional)
`timescale 1ns/1ps
module tb_addr_4;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    addr_4_if #(.WIDTH(4)) bus ();

    addr_4 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] s, input logic cout, input logic ov);
        chk({tag, ".s"}, 32'(bus.s), 32'(s));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(cout));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    endtask

    task automatic chk_flags(input string tag, input logic ovf, input logic zero);
`ifdef ADDR_4_FLAGS_EN
        chk({tag, ".ovf"}, 32'(bus.ovf), 32'(ovf));
        chk({tag, ".zero"}, 32'(bus.zero), 32'(zero));
`else
        if (ovf === 1'bx && zero === 1'bx) $display("flags unused in %s", tag);
`endif
    endtask

    initial begin
        logic [4:0] exp5;
        logic       exp_ovf;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        step(4'hF, 4'hF, 1'b1, 1'b1);
        chk_out("rst0", 4'h0, 1'b0, 1'b0);
        chk_flags("rst0", 1'b0, 1'b0);
        step(4'hF, 4'hF, 1'b1, 1'b1);
        chk_out("rst1", 4'h0, 1'b0, 1'b0);
        chk_flags("rst1", 1'b0, 1'b0);
        rst = 1'b0;

        step(4'h0, 4'h1, 1'b0, 1'b1); chk_out("basic0", 4'h1, 1'b0, 1'b1);
        step(4'h0, 4'h1, 1'b1, 1'b1); chk_out("basic1", 4'h2, 1'b0, 1'b1);
        step(4'h1, 4'h1, 1'b1, 1'b1); chk_out("basic2", 4'h3, 1'b0, 1'b1);

        step(4'hF, 4'hF, 1'b0, 1'b1); chk_out("carry0", 4'hE, 1'b1, 1'b1);
        step(4'hF, 4'hF, 1'b1, 1'b1); chk_out("carry1", 4'hF, 1'b1, 1'b1);
        step(4'hF, 4'h0, 1'b1, 1'b1); chk_out("carry2", 4'h0, 1'b1, 1'b1);
        chk_flags("carry2", 1'b0, 1'b1);

        step(4'h7, 4'h1, 1'b0, 1'b1); chk_out("ovf0", 4'h8, 1'b0, 1'b1);
        chk_flags("ovf0", 1'b1, 1'b0);
        step(4'h8, 4'h8, 1'b0, 1'b1); chk_out("ovf1", 4'h0, 1'b1, 1'b1);
        chk_flags("ovf1", 1'b1, 1'b1);
        step(4'h7, 4'h8, 1'b0, 1'b1); chk_out("ovf2", 4'hF, 1'b0, 1'b1);
        chk_flags("ovf2", 1'b0, 1'b0);

        step(4'h2, 4'h3, 1'b0, 1'b1); chk_out("gap0", 4'h5, 1'b0, 1'b1);
        step(4'hx, 4'hx, 1'bx, 1'b0); chk_out("gap1", 4'h5, 1'b0, 1'b0);
        chk_flags("gap1", 1'b0, 1'b0);
        step(4'h4, 4'h4, 1'b1, 1'b1); chk_out("gap2", 4'h9, 1'b0, 1'b1);
        chk_flags("gap2", 1'b1, 1'b0);

        rst = 1'b1;
        step(4'h6, 4'h6, 1'b0, 1'b1); chk_out("midrst0", 4'h0, 1'b0, 1'b0);
        chk_flags("midrst0", 1'b0, 1'b0);
        rst = 1'b0;
        step(4'h9, 4'h9, 1'b1, 1'b0); chk_out("midrst1", 4'h0, 1'b0, 1'b0);
        step(4'h1, 4'h2, 1'b0, 1'b1); chk_out("midrst2", 4'h3, 1'b0, 1'b1);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(v[3:0], v[7:4], v[8], 1'b1);
            exp5    = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
            exp_ovf = (v[3] == v[7]) && (exp5[3] != v[3]);
            chk("exh.sum", 32'({bus.cout, bus.s}), 32'(exp5));
            chk("exh.out_valid", 32'(bus.out_valid), 32'd1);
            chk_flags("exh", exp_ovf, exp5[3:0] == 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/addr_4.md
ADDR_4 -- requirements
Module: addr_4

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; SHALL be >= 1; all REQs are stated for the default.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WIDTH  operand A, unsigned.
REQ-005 b  input  WIDTH  operand B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  a/b/cin are valid this cycle.
REQ-008 s  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH.
REQ-009 cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-010 out_valid  output  1  s/cout hold a new result this cycle.
REQ-011 ovf  output  1  registered two's-complement overflow flag; present only with ADDR_4_FLAGS_EN.
REQ-012 zero  output  1  registered flag, high when s == 0; present only with ADDR_4_FLAGS_EN.

Function
REQ-013 Sum: {cout, s} SHALL equal the (WIDTH+1)-bit result of a + b + cin; no saturation, wrap modulo 2^WIDTH.
REQ-014 Datapath SHALL be a carry-lookahead adder: per-bit g=a&b, p=a^b; carries from g/p/cin; s = p ^ carry-in of each bit.
REQ-015 Latency: exactly 1 clock; inputs sampled at edge N with in_valid=1 appear on s/cout with out_valid=1 after edge N.
REQ-016 Throughput: one result per cycle; back-to-back in_valid SHALL yield back-to-back out_valid; no backpressure, no stall.
REQ-017 in_valid=0 at an edge: out_valid SHALL go 0 and s/cout/ovf/zero SHALL hold their previous values.
REQ-018 ovf SHALL be 1 when a[MSB]==b[MSB] and s[MSB]!=a[MSB], else 0.
REQ-019 zero SHALL be 1 when s==0, including the wrap case (e.g. 15+0+1 → s=0, cout=1, zero=1).
REQ-020 Outputs SHALL be driven only from flops; no combinational path from inputs to outputs.
REQ-021 X/Z on inputs while in_valid=0 SHALL NOT affect outputs.

Reset
REQ-022 rst=1 at a rising edge SHALL set s=0, cout=0, out_valid=0, ovf=0, zero=0, overriding in_valid in the same cycle.
REQ-023 rst asserted mid-stream SHALL discard the in-flight operation; the first result after release comes from the first in_valid sampled with rst=0.
REQ-024 With rst=0, the first edge SHALL resume normal operation; no extra warm-up cycle.

Configuration
REQ-025 Macro ADDR_4_FLAGS_EN: when defined, ovf and zero ports plus their flops SHALL exist per REQ-018/019; when undefined, these ports and logic SHALL be absent and s/cout/out_valid behaviour SHALL be unchanged.

Verification
REQ-026 Reset: rst=1 for 2 cycles with in_valid=1, a=F, b=F → s=0, cout=0, out_valid=0 throughout; ovf=0 and zero=0 when ADDR_4_FLAGS_EN is defined.
REQ-027 Basic, one per cycle, each output 1 cycle later: (a,b,cin)=(0,1,0)→s=1,cout=0; (0,1,1)→s=2,cout=0; (1,1,1)→s=3,cout=0.
REQ-028 Carry: (F,F,0)→s=E,cout=1; (F,F,1)→s=F,cout=1; (F,0,1)→s=0,cout=1, zero=1 when ADDR_4_FLAGS_EN is defined.
REQ-029 Overflow, with ADDR_4_FLAGS_EN: (7,1,0)→s=8,ovf=1; (8,8,0)→s=0,cout=1,ovf=1,zero=1; (7,8,0)→s=F,ovf=0.
REQ-030 Valid gaps and reset: in_valid pattern 1,0,1 → out_valid 1,0,1 with s held during the gap; rst=1 in the cycle after a valid input → that result is never presented.
REQ-031 Exhaustive: all 512 (a,b,cin) combinations back-to-back; each {cout,s} SHALL match a+b+cin exactly one cycle later.
